serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port x  input  WIDTH  operand A.
REQ-007 SHALL have port y  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for add mode.
REQ-009 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port s  output  WIDTH  sum/difference.
REQ-013 SHALL have port c  output  1  carry-out; in subtract mode 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  signed overflow, present only per REQ-031.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: in_ready=1, out_valid=0; in_valid=1 on an edge -> latch x, y, cin, sub, clear bit counter, go RUN.
REQ-017 Latched operands SHALL be unaffected by later changes on x, y, cin, sub.
REQ-018 Effective operands: add -> A=x, B=y, carry0=cin; subtract -> A=x, B=~y, carry0=1, cin ignored.
REQ-019 RUN: exactly one full-adder bit step per cycle, LSB first; bit i of s = A[i]^B[i]^carry, carry <= majority(A[i],B[i],carry).
REQ-020 RUN SHALL last exactly WIDTH cycles; counter 0..WIDTH-1, after bit WIDTH-1 go DONE.
REQ-021 Latency: operands accepted on edge E0 -> out_valid=1 after edge E(WIDTH); in_ready=0 from E0 until DONE handshake.
REQ-022 Result SHALL equal (A + B + carry0) mod 2^WIDTH, c = bit WIDTH of that sum.
REQ-023 DONE: out_valid=1; s, c (and ovf) SHALL stay stable while out_ready=0, indefinitely.
REQ-024 DONE with out_ready=1 on an edge -> go IDLE; in_ready=1 the following cycle (no same-cycle accept in DONE).
REQ-025 in_valid SHALL be ignored in RUN and DONE; out_ready SHALL be ignored in IDLE and RUN.
REQ-026 s SHALL show intermediate partial-sum bits during RUN; consumers SHALL only sample when out_valid=1.

Reset
REQ-027 rst_n=0 on a rising edge SHALL force IDLE, s=0, c=0, ovf=0, out_valid=0, counter=0, latched operands=0.
REQ-028 in_ready SHALL read 1 in the first cycle after reset is sampled.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid is produced for it.
REQ-030 Reset SHALL override any simultaneous in_valid/out_ready handshake.

Configuration
REQ-031 Macro SERIAL_ADDER_OVF_EN: defined -> port ovf exists, ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, updated at the final RUN step, held in DONE; undefined -> port ovf and its logic absent, all other behaviour identical.

Verification
REQ-032 WIDTH=8, add, x=0x0F, y=0x01, cin=0 -> out_valid exactly 8 cycles after accept, s=0x10, c=0.
REQ-033 WIDTH=8, add, x=0xFF, y=0x01, cin=0 -> s=0x00, c=1; same with cin=1 -> s=0x01, c=1.
REQ-034 WIDTH=8, sub, x=0x05, y=0x07, cin=1 -> s=0xFE, c=0; x=0x07, y=0x05 -> s=0x02, c=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE, toggle x/y/in_valid -> s, c stable, in_ready=0, accept only after handshake.
REQ-036 Assert rst_n=0 after bit 3 of a RUN -> next cycle in_ready=1, out_valid=0, s=0, c=0; new operation then completes correctly.
REQ-037 With SERIAL_ADDER_OVF_EN, WIDTH=8, add 0x7F+0x01 -> s=0x80, ovf=1; 0x80 sub 0x01 -> s=0x7F, ovf=1; 0x01+0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per cycle, LSB first, with valid/ready handshakes.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and results hold while out_ready is 0.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;

    assign sum_bit    = a_q[cnt] ^ b_q[cnt] ^ carry;
    assign carry_next = (a_q[cnt] & b_q[cnt]) | (a_q[cnt] & carry) | (b_q[cnt] & carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            s         <= '0;
            c         <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is x + ~y + 1; cin only matters for add.
                        a_q      <= x;
                        b_q      <= sub ? ~y : y;
                        carry    <= sub ? 1'b1 : cin;
                        cnt      <= '0;
                        s        <= '0;
                        c        <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf      <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s[cnt] <= sum_bit;
                    carry  <= carry_next;
                    if (cnt == CW'(WIDTH - 1)) begin
                        c         <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here.
                        ovf       <= carry ^ carry_next;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, add/sub results, back-pressure and reset abort.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation end to end and checks latency, result and handshake release.
    task automatic test_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] yb,
                           input logic ci, input logic sb,
                           input logic [WIDTH-1:0] exp_s, input logic exp_c,
                           input logic exp_ovf, input string name);
        int lat;
        lat = 0;
        while (!in_ready && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready_wait got=%b exp=1", name, in_ready);
        end
        x = xa; y = yb; cin = ci; sub = sb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        x = ~xa; y = ~yb; cin = ~ci; sub = ~sb;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s in_ready_after_accept got=%b exp=0", name, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != WIDTH || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, WIDTH);
        end
        checks++;
        if (s !== exp_s) begin
            failures++;
            $display("FAIL %s sum got=%h exp=%h", name, s, exp_s);
        end
        checks++;
        if (c !== exp_c) begin
            failures++;
            $display("FAIL %s carry got=%b exp=%b", name, c, exp_c);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== exp_ovf) begin
            failures++;
            $display("FAIL %s ovf got=%b exp=%b", name, ovf, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("unexpected unknown ovf expectation in %s", name);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s release got in_ready=%b out_valid=%b exp 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        x = 8'hAA; y = 8'h55; cin = 1'b1; sub = 1'b0;
        step();
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b s=%h c=%b exp 1/0/00/0",
                     in_ready, out_valid, s, c);
        end
    endtask

    task automatic test_add_sub;
        test_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        test_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        test_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "add_ff_01_cin");
        test_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
        test_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, "sub_07_05");
        test_op(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "add_aa_55_cin");
        test_op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add_3c_5a");
        test_op(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub_00_00");
        test_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        test_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        test_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "add_01_01");
    endtask

    task automatic test_back_pressure;
        int lat;
        x = 8'h12; y = 8'h34; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            in_valid = i[0];
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 8'h47 || c !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d got out_valid=%b in_ready=%b s=%h c=%b exp 1/0/47/0",
                         i, out_valid, in_ready, s, c);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        test_op(8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, "after_hold");
    endtask

    task automatic test_reset_abort;
        x = 8'hAA; y = 8'h55; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (s !== 8'h0F) begin
            failures++;
            $display("FAIL partial_sum got=%h exp=0f", s);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got in_ready=%b out_valid=%b s=%h c=%b exp 1/0/00/0",
                     in_ready, out_valid, s, c);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_valid_%0d got=%b exp=0", i, out_valid);
            end
        end
        test_op(8'h81, 8'h81, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1, "after_abort");
    endtask

    task automatic test_reset_in_done;
        x = 8'h11; y = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) step();
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'h00) begin
            failures++;
            $display("FAIL reset_in_done got in_ready=%b out_valid=%b s=%h exp 1/0/00",
                     in_ready, out_valid, s);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add_sub();
        test_back_pressure();
        test_reset_abort();
        test_reset_in_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
